// File: rtl/morse_tx_ctrl_pkg.sv
// Shared constants for the Morse letter transmitter: FSM encoding and the
// letter-to-pulse-pattern table (left-aligned, MSB sent first).
package morse_tx_ctrl_pkg;

  localparam int MORSE_WIDTH = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  // 1 = LED on; a dot is one unit, a dash three, gaps one unit.
  localparam logic [MORSE_WIDTH-1:0] MORSE_PAT [8] = '{
    14'b10111000000000,  // A
    14'b11101010100000,  // B
    14'b11101011101000,  // C
    14'b11101010000000,  // D
    14'b10000000000000,  // E
    14'b10101110100000,  // F
    14'b11101110100000,  // G
    14'b10101010000000   // H
  };

  localparam logic [3:0] MORSE_LEN [8] = '{
    4'd5, 4'd9, 4'd11, 4'd7, 4'd1, 4'd9, 4'd9, 4'd7
  };

endpackage

// File: rtl/morse_tick_div.sv
// Symbol-unit divider: counts 0..TICK_CYCLES-1 while enabled and flags the
// last cycle of each unit with a registered one-cycle tick.
module morse_tick_div #(
  parameter int TICK_CYCLES = 25_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int DIV_W = $clog2(TICK_CYCLES);

  logic [DIV_W-1:0] count;

  // tick is precomputed one cycle early so it is high exactly while
  // count == TICK_CYCLES-1, without a combinational compare on the output.
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous here, so it is just the first branch of the
    // clocked block and stays out of the sensitivity list.
    if (!reset_n || clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= (count == DIV_W'(TICK_CYCLES - 2));
      if (count == DIV_W'(TICK_CYCLES - 1)) count <= '0;
      else                                  count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/morse_tx_ctrl.sv
// Sequencer for an external left-shift register that blinks one Morse letter
// (A..H): loads the letter's pattern, then shifts once per Morse unit.
module morse_tx_ctrl
  import morse_tx_ctrl_pkg::*;
#(
  parameter int WIDTH       = MORSE_WIDTH,
  parameter int TICK_CYCLES = 25_000_000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       letter,
  input  logic             shift_msb,
  output logic [WIDTH-1:0] pattern,
  output logic             par_load,
  output logic             enable,
  output logic             led,
  output logic             busy,
  output logic             done
);

  state_t     state;
  logic [3:0] remaining;
  logic       tick;

  // The divider only runs in SEND, so every letter starts on a fresh unit.
  morse_tick_div #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_div (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (state != SEND),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      pattern   <= '0;
      remaining <= '0;
      par_load  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      par_load <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pattern   <= WIDTH'(MORSE_PAT[letter]) << (WIDTH - MORSE_WIDTH);
            remaining <= MORSE_LEN[letter];
            par_load  <= 1'b1;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: state <= SEND;
        SEND: begin
          if (tick) begin
            remaining <= remaining - 4'd1;
            if (remaining == 4'd1) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated with SEND so the shifter never sees a strobe outside a letter and
  // the LED follows the shifter with no added latency.
  assign enable = tick && (state == SEND);
  assign led    = shift_msb && (state == SEND);

endmodule
